// File: rtl/rx_frame_sr_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_pkg
// Shared types and helpers for the UART receive frame assembler.
//   rx_state_t     : assembler FSM states (IDLE, SHIFT, DONE)
//   parity_mode_t  : decoded parity selection (NONE, EVEN, ODD)
//   MIN_DATA_BITS  : narrowest legal data field
//   clamp_size()   : maps an out-of-range data_size onto the widest field
//   decode_parity(): maps the raw 2-bit parity_mode onto parity_mode_t
// ---------------------------------------------------------------------------
package rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  localparam int MIN_DATA_BITS = 5;

  // Any request outside MIN_DATA_BITS..max_bits falls back to the widest field
  // so the frame length is always well defined.
  function automatic logic [3:0] clamp_size(input logic [3:0] size,
                                            input int max_bits);
    if ((int'(size) < MIN_DATA_BITS) || (int'(size) > max_bits)) begin
      return 4'(max_bits);
    end
    return size;
  endfunction

  // Encoding 11 is reserved and behaves as "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rx_frame_sr_if.sv
// ---------------------------------------------------------------------------
// rx_frame_sr_if
// Bundles the control inputs and status outputs of the receive frame
// assembler.
//   frame_start   : start bit validated, arm a new frame
//   shift_strobe  : one-cycle mid-bit sample strobe
//   serial_in     : synchronised RX line
//   data_size     : data bits per frame
//   parity_mode   : 00 none, 01 even, 10 odd, 11 none
//   packet_data   : received data, right aligned, zero extended
//   stop_bit      : sampled stop bit
//   framing_error : stop bit sampled as 0
//   parity_error  : parity mismatch on last frame
//   frame_done    : one-cycle pulse when the outputs update
//   busy          : frame in progress
// Modports: master drives the controls (timer FSM / bench), slave is the
// assembler.
// ---------------------------------------------------------------------------
interface rx_frame_sr_if #(
  parameter int MAX_DATA_BITS = 9
);
  logic                     frame_start;
  logic                     shift_strobe;
  logic                     serial_in;
  logic [3:0]               data_size;
  logic [1:0]               parity_mode;
  logic [MAX_DATA_BITS-1:0] packet_data;
  logic                     stop_bit;
  logic                     framing_error;
  logic                     parity_error;
  logic                     frame_done;
  logic                     busy;

  modport master (
    output frame_start, shift_strobe, serial_in, data_size, parity_mode,
    input  packet_data, stop_bit, framing_error, parity_error, frame_done, busy
  );

  modport slave (
    input  frame_start, shift_strobe, serial_in, data_size, parity_mode,
    output packet_data, stop_bit, framing_error, parity_error, frame_done, busy
  );
endinterface

// File: rtl/rx_frame_sr_bit_counter.sv
// ---------------------------------------------------------------------------
// rx_bit_counter
// Bit position counter for the frame assembler.
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   clear  : synchronous clear to 0 (frame armed)
//   incr   : advance by one (bit captured)
//   total  : number of bits in the current frame
//   count  : index of the next bit to capture
//   last   : count addresses the final bit (stop bit) of the frame
// ---------------------------------------------------------------------------
module rx_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Clear has priority so an abort on the same cycle as a strobe restarts at 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == (total - CNT_W'(1)));

endmodule

// File: rtl/rx_frame_sr.sv
// ---------------------------------------------------------------------------
// rx_frame_sr
// UART receive frame assembler. Captures serial bits LSB first on
// shift_strobe for a runtime-selected data size, an optional parity bit and a
// stop bit, then presents right-aligned data with stop/framing/parity status
// and a one-cycle frame_done pulse.
// Ports:
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : rx_frame_sr_if.slave (controls in, data/status out)
// Parameters:
//   MAX_DATA_BITS : widest supported data field (5..15)
//   CNT_W         : bit counter width, derived, do not override
// Configuration macro:
//   RX_PARITY_EN  : when defined, parity_mode is honoured and parity is
//                   checked; otherwise parity_mode is ignored, frames carry
//                   no parity bit and parity_error is tied 0.
// ---------------------------------------------------------------------------
module rx_frame_sr
  import rx_frame_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int CNT_W         = $clog2(MAX_DATA_BITS + 3)
) (
  input  logic        clk,
  input  logic        n_rst,
  rx_frame_sr_if.slave bus
);

  // Capture register holds data plus the parity bit; the stop bit is taken
  // straight from serial_in on the final strobe.
  localparam int SR_W = MAX_DATA_BITS + 1;

  rx_state_t                state;
  logic [3:0]               eff_size;
  logic [CNT_W-1:0]         total;
  logic [SR_W-1:0]          shift_reg;
  logic [CNT_W-1:0]         count;
  logic                     last;
  logic                     arm;
  logic                     take;
  logic [3:0]               next_size;
  logic [CNT_W-1:0]         next_total;
  logic [MAX_DATA_BITS-1:0] data_masked;

  // frame_start arms from any state and always beats a coincident strobe.
  assign arm       = bus.frame_start;
  assign take      = (state == SHIFT) && bus.shift_strobe && !bus.frame_start;
  assign next_size = clamp_size(bus.data_size, MAX_DATA_BITS);

  rx_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (arm),
    .incr  (take),
    .total (total),
    .count (count),
    .last  (last)
  );

  // Bits at or above the latched size may hold the parity bit or stale
  // captures, so they are forced to zero before presentation.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      data_masked[i] = shift_reg[i] & (i < int'(eff_size));
    end
  end

`ifdef RX_PARITY_EN
  parity_mode_t par_mode;
  logic         par_en_next;
  logic         par_bit;
  logic         par_xor;
  logic         par_err_calc;

  assign par_en_next = (decode_parity(bus.parity_mode) != PAR_NONE);
  assign next_total  = CNT_W'(next_size) + CNT_W'(par_en_next) + CNT_W'(1);

  // Parity bit sits directly above the data field, at index eff_size.
  always_comb begin
    par_bit = 1'b0;
    for (int i = 0; i < SR_W; i++) begin
      if (int'(eff_size) == i) begin
        par_bit = shift_reg[i];
      end
    end
    par_xor = (^data_masked) ^ par_bit;
    case (par_mode)
      PAR_EVEN: par_err_calc = par_xor;
      PAR_ODD:  par_err_calc = ~par_xor;
      default:  par_err_calc = 1'b0;
    endcase
  end
`else
  assign next_total       = CNT_W'(next_size) + CNT_W'(1);
  assign bus.parity_error = 1'b0;
`endif

  // Frame FSM: arming latches the frame format and clears the capture
  // register; each accepted strobe writes serial_in at the counter position;
  // the final strobe commits data and status and raises frame_done for the
  // one cycle spent in DONE. Aborts leave the previous results untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= IDLE;
      eff_size          <= '0;
      total             <= '0;
      shift_reg         <= '0;
      bus.packet_data   <= '0;
      bus.stop_bit      <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.busy          <= 1'b0;
`ifdef RX_PARITY_EN
      par_mode          <= PAR_NONE;
      bus.parity_error  <= 1'b0;
`endif
    end else begin
      bus.frame_done <= 1'b0;
      if (arm) begin
        state     <= SHIFT;
        bus.busy  <= 1'b1;
        shift_reg <= '0;
        eff_size  <= next_size;
        total     <= next_total;
`ifdef RX_PARITY_EN
        par_mode  <= decode_parity(bus.parity_mode);
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          SHIFT: begin
            if (take) begin
              for (int i = 0; i < SR_W; i++) begin
                if (count == CNT_W'(i)) begin
                  shift_reg[i] <= bus.serial_in;
                end
              end
              if (last) begin
                state             <= DONE;
                bus.busy          <= 1'b0;
                bus.frame_done    <= 1'b1;
                bus.packet_data   <= data_masked;
                bus.stop_bit      <= bus.serial_in;
                bus.framing_error <= ~bus.serial_in;
`ifdef RX_PARITY_EN
                bus.parity_error  <= par_err_calc;
`endif
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sr.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_sr
// Directed bench for rx_frame_sr. Expected frame results are queued when the
// stop bit is driven and checked by a monitor whenever frame_done pulses.
// Honours RX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_rx_frame_sr;

  localparam int MAXB = 9;

  typedef struct {
    logic [8:0] data;
    logic       stop;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  rx_frame_sr_if #(.MAX_DATA_BITS(MAXB)) bus ();

  rx_frame_sr #(.MAX_DATA_BITS(MAXB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  task automatic check_output(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference parity: even requires XOR(data, pbit)=0, odd requires 1.
  function automatic logic exp_parity(input logic [1:0] mode,
                                      input logic [8:0] data, input logic pbit);
`ifdef RX_PARITY_EN
    if (mode == 2'b01) return (^data) ^ pbit;
    if (mode == 2'b10) return ~((^data) ^ pbit);
`endif
    return 1'b0;
  endfunction

  // Monitor: every frame_done must be a single-cycle pulse matching the
  // oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && bus.frame_done) begin
      check_output("done_width", 16'(done_prev), 16'h0);
      if (sb.size() == 0) begin
        check_output("spurious_done", 16'h1, 16'h0);
      end else begin
        e = sb.pop_front();
        check_output("packet_data", 16'(bus.packet_data), 16'(e.data));
        check_output("stop_bit", 16'(bus.stop_bit), 16'(e.stop));
        check_output("framing_error", 16'(bus.framing_error), 16'(e.ferr));
        check_output("parity_error", 16'(bus.parity_error), 16'(e.perr));
      end
    end
    done_prev = bus.frame_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] size, input logic [1:0] pmode);
    bus.frame_start = 1'b1;
    bus.data_size   = size;
    bus.parity_mode = pmode;
    tick();
    bus.frame_start = 1'b0;
    check_output("busy_after_start", 16'(bus.busy), 16'h1);
  endtask

  task automatic strobe_bit(input logic b);
    bus.serial_in    = b;
    bus.shift_strobe = 1'b1;
    tick();
    bus.shift_strobe = 1'b0;
    tick();
  endtask

  task automatic send_data(input logic [14:0] bits, input int n);
    for (int i = 0; i < n; i++) strobe_bit(bits[i]);
  endtask

  task automatic send_parity(input logic pbit);
`ifdef RX_PARITY_EN
    strobe_bit(pbit);
`else
    if (pbit === 1'bx) $display("[TB] unexpected parity value");
`endif
  endtask

  // Drives the stop bit; frame_done must be high right after that edge and
  // low one cycle later. With rearm, frame_start is held during DONE.
  task automatic finish_frame(input logic stop, input logic [8:0] data,
                              input logic perr, input logic rearm);
    sb.push_back('{data, stop, ~stop, perr});
    bus.serial_in    = stop;
    bus.shift_strobe = 1'b1;
    tick();
    bus.shift_strobe = 1'b0;
    check_output("done_latency", 16'(bus.frame_done), 16'h1);
    check_output("busy_in_done", 16'(bus.busy), 16'h0);
    if (rearm) bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check_output("done_one_cycle", 16'(bus.frame_done), 16'h0);
    if (rearm) check_output("busy_rearm_done", 16'(bus.busy), 16'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, 16'(bus.packet_data), 16'h0);
    check_output({tag, "_stop"}, 16'(bus.stop_bit), 16'h0);
    check_output({tag, "_ferr"}, 16'(bus.framing_error), 16'h0);
    check_output({tag, "_perr"}, 16'(bus.parity_error), 16'h0);
    check_output({tag, "_done"}, 16'(bus.frame_done), 16'h0);
    check_output({tag, "_busy"}, 16'(bus.busy), 16'h0);
  endtask

  initial begin
    bus.frame_start  = 1'b0;
    bus.shift_strobe = 1'b0;
    bus.serial_in    = 1'b1;
    bus.data_size    = 4'd8;
    bus.parity_mode  = 2'b00;
    n_rst            = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();

    // 8N1 frame: LSB-first 1,0,1,0,0,1,0,1 -> 0xA5, good stop
    apply_stimulus(4'd8, 2'b00);
    send_data(15'h0A5, 8);
    finish_frame(1'b1, 9'h0A5, 1'b0, 1'b0);

    // 5-bit frame with bad stop; format changes mid-frame must be ignored
    apply_stimulus(4'd5, 2'b00);
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    bus.data_size   = 4'd8;
    bus.parity_mode = 2'b01;
    strobe_bit(1'b1);
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    finish_frame(1'b0, 9'h00D, 1'b0, 1'b0);

    // Even parity, data 0x03, parity bit 1 then 0
    apply_stimulus(4'd8, 2'b01);
    send_data(15'h003, 8);
    send_parity(1'b1);
    finish_frame(1'b1, 9'h003, exp_parity(2'b01, 9'h003, 1'b1), 1'b0);

    apply_stimulus(4'd8, 2'b01);
    send_data(15'h003, 8);
    send_parity(1'b0);
    finish_frame(1'b1, 9'h003, exp_parity(2'b01, 9'h003, 1'b0), 1'b0);

    // Odd parity, data 0x03, parity bit 0
    apply_stimulus(4'd8, 2'b10);
    send_data(15'h003, 8);
    send_parity(1'b0);
    finish_frame(1'b1, 9'h003, exp_parity(2'b10, 9'h003, 1'b0), 1'b0);

    // Out-of-range sizes clamp to 9 data bits
    apply_stimulus(4'd12, 2'b00);
    send_data(15'h1FF, 9);
    finish_frame(1'b1, 9'h1FF, 1'b0, 1'b0);

    apply_stimulus(4'd3, 2'b00);
    send_data(15'h155, 9);
    finish_frame(1'b1, 9'h155, 1'b0, 1'b0);

    // Abort after 3 strobes: no frame_done, previous outputs kept
    apply_stimulus(4'd8, 2'b00);
    send_data(15'h007, 3);
    apply_stimulus(4'd6, 2'b00);
    check_output("abort_hold_data", 16'(bus.packet_data), 16'h155);
    send_data(15'h02A, 6);
    finish_frame(1'b1, 9'h02A, 1'b0, 1'b0);

    // frame_start coincident with a strobe: the strobe is dropped
    apply_stimulus(4'd5, 2'b00);
    strobe_bit(1'b1);
    strobe_bit(1'b1);
    bus.frame_start  = 1'b1;
    bus.shift_strobe = 1'b1;
    bus.serial_in    = 1'b1;
    bus.data_size    = 4'd5;
    tick();
    bus.frame_start  = 1'b0;
    bus.shift_strobe = 1'b0;
    tick();
    send_data(15'h000, 5);
    finish_frame(1'b1, 9'h000, 1'b0, 1'b0);

    // frame_start during DONE: pulse still seen, next frame armed
    apply_stimulus(4'd5, 2'b00);
    send_data(15'h01F, 5);
    bus.data_size = 4'd5;
    finish_frame(1'b1, 9'h01F, 1'b0, 1'b1);
    send_data(15'h006, 5);
    finish_frame(1'b1, 9'h006, 1'b0, 1'b0);

    // Asynchronous reset mid-frame clears everything without a clock edge
    apply_stimulus(4'd8, 2'b00);
    send_data(15'h00F, 4);
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    n_rst = 1'b1;
    tick();

    check_output("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
